// File: rtl/lcd_blit_pkg.sv
// Shared constants for the LCD rectangle-blit sequencer: FSM state codes,
// default LCD opcodes, descriptor field offsets and AHB transfer encodings.
package lcd_blit_pkg;

  // FSM state codes
  localparam logic [3:0] StIdle   = 4'd0;
  localparam logic [3:0] StLdWh   = 4'd1;
  localparam logic [3:0] StLdBase = 4'd2;
  localparam logic [3:0] StCmdC   = 4'd3;
  localparam logic [3:0] StArgC   = 4'd4;
  localparam logic [3:0] StCmdR   = 4'd5;
  localparam logic [3:0] StArgR   = 4'd6;
  localparam logic [3:0] StCmdM   = 4'd7;
  localparam logic [3:0] StAd     = 4'd8;
  localparam logic [3:0] StDa     = 4'd9;
  localparam logic [3:0] StEmit   = 4'd10;
  localparam logic [3:0] StDone   = 4'd11;

  // Default LCD opcodes
  localparam logic [7:0] DefCmdCol = 8'h2A;
  localparam logic [7:0] DefCmdRow = 8'h2B;
  localparam logic [7:0] DefCmdRam = 8'h2C;

  // Descriptor field offsets (W0 = {y0, x0}, W1 = {h-1, w-1})
  localparam int unsigned XOff = 0;
  localparam int unsigned YOff = 16;
  localparam int unsigned WOff = 0;
  localparam int unsigned HOff = 16;

  // AHB-Lite HTRANS encodings
  localparam logic [1:0] HtransIdle   = 2'b00;
  localparam logic [1:0] HtransNonseq = 2'b10;

  // Right-justify the byte lane addressed by the low address bits.
  function automatic logic [31:0] lane_align(input logic [31:0] data, input logic [1:0] offs);
    return data >> {offs, 3'b000};
  endfunction

endpackage

// File: rtl/lcd_blit_ctrl_if.sv
// Bus bundle of the blit sequencer: request FIFO, LCD output FIFO, AHB-Lite
// read master and job status.
interface lcd_blit_ctrl_if;
  logic [31:0] req_data;
  logic        req_empty;
  logic        req_rinc;
  logic [7:0]  out_data;
  logic        out_dc;
  logic        out_winc;
  logic        out_full;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        busy;
  logic        done;

  // The sequencer side
  modport master (
    input  req_data, req_empty, out_full, HREADY, HRDATA,
    output req_rinc, out_data, out_dc, out_winc, HADDR, HTRANS, HSIZE, busy, done
  );

  // FIFOs, AHB slave and status consumer
  modport slave (
    output req_data, req_empty, out_full, HREADY, HRDATA,
    input  req_rinc, out_data, out_dc, out_winc, HADDR, HTRANS, HSIZE, busy, done
  );
endinterface

// File: rtl/lcd_byte_ser.sv
// Byte serializer: loads a right-justified word of 1..4 bytes and presents
// it MSB first, advancing one byte per accepted push.
module lcd_byte_ser (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_word,
  input  logic [2:0]  load_bytes,
  input  logic        shift,
  output logic [7:0]  byte_out,
  output logic        last
);

  logic [31:0] sreg_q;
  logic [2:0]  left_q;

  // Left-justify on load so the next byte is always at the top.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg_q <= '0;
      left_q <= '0;
    end else if (load) begin
      sreg_q <= load_word << {(3'd4 - load_bytes), 3'b000};
      left_q <= load_bytes;
    end else if (shift && (left_q != 3'd0)) begin
      sreg_q <= sreg_q << 8;
      left_q <= left_q - 3'd1;
    end
  end

  assign byte_out = sreg_q[31:24];
  assign last     = (left_q == 3'd1);

endmodule

// File: rtl/lcd_blit_ctrl.sv
// LCD rectangle-blit sequencer. Pops a three-word descriptor, sends the
// column/row window and RAM-write command, then reads each pixel over AHB-Lite
// and streams it byte-serially to the LCD FIFO.
// Optional screen clipping: define LCD_BLIT_CLIP_EN.
module lcd_blit_ctrl
  import lcd_blit_pkg::*;
#(
  parameter int unsigned COORD_W   = 9,
  parameter int unsigned PIX_BYTES = 2,
  parameter int unsigned LCD_W     = 320,
  parameter int unsigned LCD_H     = 480,
  parameter logic [7:0]  CMD_COL   = DefCmdCol,
  parameter logic [7:0]  CMD_ROW   = DefCmdRow,
  parameter logic [7:0]  CMD_RAM   = DefCmdRam
) (
  input logic             clk,
  input logic             rst_n,
  lcd_blit_ctrl_if.master bus
);

  localparam int unsigned PixShift  = (PIX_BYTES == 4) ? 2 : (PIX_BYTES == 2) ? 1 : 0;
  localparam logic [2:0]  PixBytesW = 3'(PIX_BYTES);

  logic [3:0]  state_q, state_d;
  logic [15:0] x0_q, y0_q, wm1_q, hm1_q, col_q, row_q;
  logic [31:0] ptr_q;

  logic [COORD_W:0] x_sum, y_sum;
  logic [15:0] x_end, y_end, col_last, row_last;
  logic        drop;
  logic        in_ld, in_arg, in_emit, in_cmd;
  logic        pop, push, pix_last;
  logic        ser_load, ser_shift, ser_last;
  logic [31:0] ser_word;
  logic [2:0]  ser_bytes;
  logic [7:0]  ser_byte;

  // Window end in COORD_W+1 bits so the sum never wraps inside the coordinate range.
  assign x_sum = {1'b0, x0_q[COORD_W-1:0]} + {1'b0, wm1_q[COORD_W-1:0]};
  assign y_sum = {1'b0, y0_q[COORD_W-1:0]} + {1'b0, hm1_q[COORD_W-1:0]};

`ifdef LCD_BLIT_CLIP_EN
  localparam logic [15:0] XMax = 16'(LCD_W - 1);
  localparam logic [15:0] YMax = 16'(LCD_H - 1);
  logic unused_clip;

  assign x_end    = (16'(x_sum) > XMax) ? XMax : 16'(x_sum);
  assign y_end    = (16'(y_sum) > YMax) ? YMax : 16'(y_sum);
  assign col_last = x_end - x0_q;
  assign row_last = y_end - y0_q;
  assign drop     = (x0_q > XMax) || (y0_q > YMax);
  assign unused_clip = ^hm1_q;
`else
  logic unused_dims;

  assign x_end    = 16'(x_sum);
  assign y_end    = 16'(y_sum);
  assign col_last = wm1_q;
  assign row_last = hm1_q;
  assign drop     = 1'b0;
  assign unused_dims = ^{16'(LCD_W), 16'(LCD_H)};
`endif

  assign in_ld    = (state_q == StIdle) || (state_q == StLdWh) || (state_q == StLdBase);
  assign in_cmd   = (state_q == StCmdC) || (state_q == StCmdR) || (state_q == StCmdM);
  assign in_arg   = (state_q == StArgC) || (state_q == StArgR);
  assign in_emit  = (state_q == StEmit);
  // Gate the pop with reset so no descriptor word is lost while held in reset.
  assign pop      = in_ld && !bus.req_empty && rst_n;
  assign push     = (in_cmd || in_arg || in_emit) && !bus.out_full;
  assign pix_last = (col_q == col_last) && (row_q == row_last);

  assign ser_load  = ((state_q == StCmdC || state_q == StCmdR) && push) ||
                     ((state_q == StDa) && bus.HREADY);
  assign ser_shift = push && (in_arg || in_emit);
  assign ser_bytes = (state_q == StDa) ? PixBytesW : 3'd4;

  // Serializer source: window arguments or the addressed pixel lane.
  always_comb begin
    ser_word = lane_align(bus.HRDATA, ptr_q[1:0]);
    if (state_q == StCmdC) ser_word = {x0_q, x_end};
    if (state_q == StCmdR) ser_word = {y0_q, y_end};
  end

  lcd_byte_ser u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (ser_load),
    .load_word  (ser_word),
    .load_bytes (ser_bytes),
    .shift      (ser_shift),
    .byte_out   (ser_byte),
    .last       (ser_last)
  );

  // Next-state logic; every exit through a push waits for the FIFO.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (pop) state_d = StLdWh;
      StLdWh:   if (pop) state_d = StLdBase;
      StLdBase: if (pop) state_d = drop ? StDone : StCmdC;
      StCmdC:   if (push) state_d = StArgC;
      StArgC:   if (push && ser_last) state_d = StCmdR;
      StCmdR:   if (push) state_d = StArgR;
      StArgR:   if (push && ser_last) state_d = StCmdM;
      StCmdM:   if (push) state_d = StAd;
      StAd:     if (bus.HREADY) state_d = StDa;
      StDa:     if (bus.HREADY) state_d = StEmit;
      StEmit:   if (push && ser_last) state_d = pix_last ? StDone : StAd;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Descriptor capture and pixel walk (column, row, source pointer).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x0_q  <= '0;
      y0_q  <= '0;
      wm1_q <= '0;
      hm1_q <= '0;
      col_q <= '0;
      row_q <= '0;
      ptr_q <= '0;
    end else begin
      if (pop) begin
        case (state_q)
          StIdle: begin
            x0_q <= bus.req_data[XOff +: 16];
            y0_q <= bus.req_data[YOff +: 16];
          end
          StLdWh: begin
            wm1_q <= bus.req_data[WOff +: 16];
            hm1_q <= bus.req_data[HOff +: 16];
          end
          StLdBase: begin
            ptr_q <= bus.req_data;
            col_q <= '0;
            row_q <= '0;
          end
          default: ;
        endcase
      end
      if (in_emit && push && ser_last) begin
        if (col_q == col_last) begin
          // Skip the clipped-off source columns; stride stays the full width.
          col_q <= '0;
          row_q <= row_q + 16'd1;
          ptr_q <= ptr_q + 32'(PIX_BYTES) + (32'(wm1_q - col_last) << PixShift);
        end else begin
          col_q <= col_q + 16'd1;
          ptr_q <= ptr_q + 32'(PIX_BYTES);
        end
      end
    end
  end

  // Output byte and data/command flag.
  always_comb begin
    bus.out_data = 8'h00;
    case (state_q)
      StCmdC:                 bus.out_data = CMD_COL;
      StCmdR:                 bus.out_data = CMD_ROW;
      StCmdM:                 bus.out_data = CMD_RAM;
      StArgC, StArgR, StEmit: bus.out_data = ser_byte;
      default:                bus.out_data = 8'h00;
    endcase
  end

  assign bus.out_dc   = in_arg || in_emit;
  assign bus.out_winc = push;
  assign bus.req_rinc = pop;
  assign bus.HTRANS   = (state_q == StAd) ? HtransNonseq : HtransIdle;
  assign bus.HADDR    = ptr_q;
  assign bus.HSIZE    = 3'(PixShift);
  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = (state_q == StDone);

endmodule
